// File: rtl/bnn_pkg.sv
// Shared BNN classifier constants and types.
//   BNN_NUM_CLASS / BNN_SCORE_W : score vector shape, also used by argmax
//   BNN_WORD_W / BNN_N_WORDS    : activation beat width and beats per frame
//   state_t                     : accumulator FSM states
package bnn_pkg;
  localparam int BNN_NUM_CLASS = 10;
  localparam int BNN_WORD_W    = 32;
  localparam int BNN_N_WORDS   = 8;
  localparam int BNN_SCORE_W   = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  // Bits needed to hold a count of 0..word_w set bits.
  function automatic int popcount_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction
endpackage

// File: rtl/bnn_class_score_accum_if.sv
// Beat input and score output bundle of the class score accumulator.
//   i_valid/i_ready/i_act/i_wgt : activation + weight beat stream
//   o_scores/o_valid            : packed class scores, one-cycle pulse
//
// Handshake: a beat transfers on a rising clock edge where i_valid and
// i_ready are both high. The producer keeps i_act/i_wgt stable while
// i_valid is high and i_ready is low. o_valid is a one-cycle pulse with no
// back-pressure; o_scores holds its last value while o_valid is low.
interface bnn_class_score_accum_if
  import bnn_pkg::*;
#(
  parameter int NUM_CLASS = BNN_NUM_CLASS,
  parameter int WORD_W    = BNN_WORD_W,
  parameter int SCORE_W   = BNN_SCORE_W
);
  logic                           i_valid;
  logic                           i_ready;
  logic [WORD_W-1:0]              i_act;
  logic [NUM_CLASS*WORD_W-1:0]    i_wgt;
  logic [NUM_CLASS*SCORE_W-1:0]   o_scores;
  logic                           o_valid;

  modport master (
    output i_valid, i_act, i_wgt,
    input  i_ready, o_scores, o_valid
  );

  modport slave (
    input  i_valid, i_act, i_wgt,
    output i_ready, o_scores, o_valid
  );
endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count of a WORD_W-bit word.
//   din : input word
//   cnt : number of set bits, 0..WORD_W
module bnn_popcount
  import bnn_pkg::*;
#(
  parameter int WORD_W = BNN_WORD_W,
  parameter int CNT_W  = popcount_w(BNN_WORD_W)
) (
  input  logic [WORD_W-1:0] din,
  output logic [CNT_W-1:0]  cnt
);
  // Written as a flat sum; synthesis balances it into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      cnt = cnt + CNT_W'(din[i]);
    end
  end
endmodule

// File: rtl/bnn_class_score_accum.sv
// Final fully-connected BNN layer: XNOR-popcount score per output class.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : beat input (i_valid/i_ready/i_act/i_wgt) and packed score
//                output (o_scores/o_valid), class c at [c*SCORE_W +: SCORE_W]
//   dbg_state  : current FSM state
// Each accepted beat adds the number of matching activation/weight bits to
// every class accumulator. After N_WORDS beats the FSM spends one cycle in
// OUT, pulsing o_valid and refusing input while the accumulators clear.
module bnn_class_score_accum
  import bnn_pkg::*;
#(
  parameter int NUM_CLASS = BNN_NUM_CLASS,
  parameter int WORD_W    = BNN_WORD_W,
  parameter int N_WORDS   = BNN_N_WORDS,
  parameter int SCORE_W   = BNN_SCORE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bnn_class_score_accum_if.slave bus,
  output state_t                 dbg_state
);
  localparam int CNT_W  = popcount_w(WORD_W);
  localparam int WCNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(N_WORDS - 1);

  // A full frame of matches must fit in a score, so no saturation is needed.
  if (N_WORDS * WORD_W > (2 ** SCORE_W) - 1) begin : g_width_check
    $error("bnn_class_score_accum: N_WORDS*WORD_W does not fit in SCORE_W");
  end

  state_t                       state;
  state_t                       state_nxt;
  logic [WCNT_W-1:0]            wcnt;
  logic [SCORE_W-1:0]           acc     [NUM_CLASS];
  logic [SCORE_W-1:0]           acc_sum [NUM_CLASS];
  logic [CNT_W-1:0]             pc      [NUM_CLASS];
  logic [NUM_CLASS*SCORE_W-1:0] scores_q;
  logic                         accept;
  logic                         last_beat;

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_class
    bnn_popcount #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
    ) u_popcount (
      .din (~(bus.i_act ^ bus.i_wgt[c*WORD_W +: WORD_W])),
      .cnt (pc[c])
    );
    assign acc_sum[c] = acc[c] + SCORE_W'(pc[c]);
  end

  assign accept    = bus.i_valid && (state == ACCUM);
  assign last_beat = (wcnt == WCNT_LAST);

  always_comb begin
    state_nxt   = state;
    bus.i_ready = 1'b0;
    bus.o_valid = 1'b0;
    case (state)
      ACCUM: begin
        bus.i_ready = 1'b1;
        if (accept && last_beat) state_nxt = OUT;
      end
      OUT: begin
        bus.o_valid = 1'b1;
        state_nxt   = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      wcnt     <= '0;
      scores_q <= '0;
      for (int c = 0; c < NUM_CLASS; c++) acc[c] <= '0;
    end else begin
      state <= state_nxt;
      if (state == OUT) begin
        for (int c = 0; c < NUM_CLASS; c++) acc[c] <= '0;
      end else if (accept) begin
        for (int c = 0; c < NUM_CLASS; c++) acc[c] <= acc_sum[c];
        wcnt <= last_beat ? '0 : wcnt + 1'b1;
        // Capture the totals including the last beat; this register holds
        // them through OUT and afterwards while acc restarts from zero.
        if (last_beat) begin
          for (int c = 0; c < NUM_CLASS; c++)
            scores_q[c*SCORE_W +: SCORE_W] <= acc_sum[c];
        end
      end
    end
  end

  assign bus.o_scores = scores_q;
  assign dbg_state    = state;
endmodule
